uart_register_port: RTL and testbench
=====================================

# uart_register_port

Memory-mapped UART peripheral on the hardware register bus driven by the microcontroller top level. The core reaches it through the 4 KB register window: a 12-bit index, read/write strobes and a 16-bit read value returned one cycle after the read. The block holds an 8-deep transmit FIFO, a single-byte receive holding register, and independent TX and RX bit-timing state machines. All register reads are side-effect free; every state change is caused by a write.

## Interface
- BASE_INDEX, 12'h010: register index of DATA; STATUS = BASE+1, RX_ACK = BASE+2.
- CLKS_PER_BIT, 16: clock cycles per serial bit, minimum 4, even.
- TX_DEPTH, 8: transmit FIFO entries, power of two.
- clk  in  1  system clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- register_index  in  12  register address from the core.
- register_read  in  1  read strobe for register_index.
- register_write  in  1  write strobe for register_index.
- register_write_value  in  16  write data; bits [7:0] are used.
- register_read_value  out  16  registered read data, valid the cycle after register_read.
- uart_tx  out  1  serial output, idle high.
- uart_rx  in  1  asynchronous serial input.

## Operation
- Write DATA: push write_value[7:0] into the TX FIFO. If the FIFO is full, the byte is dropped and no state changes, unless the TX FSM pops in the same cycle; in that case the push is accepted.
- Read DATA: returns {8'h00, rx_byte}.
- Read STATUS: returns {11'b0, frame_err, overrun, rx_valid, tx_idle, tx_full}.
  - tx_idle means the FIFO is empty and the TX FSM is in IDLE.
- Write STATUS: clears overrun and frame_err, regardless of data.
- Write RX_ACK: clears rx_valid, regardless of data.
- Reads of any other index return 16'h0000. Writes to any other index are ignored.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is not empty. The FIFO head is popped into a shift register on the same edge.
  - START drives 0 for CLKS_PER_BIT cycles.
  - DATA drives 8 bits, LSB first, each for CLKS_PER_BIT cycles.
  - STOP drives 1 for CLKS_PER_BIT cycles, then returns to IDLE. Queued bytes follow back-to-back with no extra idle cycle.
- RX input passes through a 2-flop synchronizer.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on synchronized rx = 0.
  - START waits CLKS_PER_BIT/2 cycles. If rx is still 0 it goes to DATA; otherwise it treats the low as a glitch and returns to IDLE.
  - DATA samples 8 bits, each CLKS_PER_BIT cycles apart, LSB first.
  - STOP samples once after CLKS_PER_BIT cycles, then returns to IDLE.
- Stop bit = 1: rx_byte is loaded and rx_valid is set. If rx_valid was already 1, overrun is set and the byte overwrites rx_byte.
- Stop bit = 0: frame_err is set; rx_byte and rx_valid are unchanged.
- A set event and a clear write to the same flag in the same cycle: the set wins.

## Timing
- Reset values:
  - uart_tx = 1, register_read_value = 0.
  - FIFO empty, all flags 0, both FSMs in IDLE, all counters 0.
- Reset asserted mid-frame: uart_tx is 1 from the cycle after the reset edge. Any partial RX byte is discarded.
- Read latency is exactly 1 cycle. register_read_value is updated only on cycles where register_read is 1, and holds otherwise.
- A DATA write at edge N makes the FIFO non-empty at N+1. The TX FSM leaves IDLE at N+1, and uart_tx goes low from N+2.
- One frame takes 10 × CLKS_PER_BIT cycles.
- STATUS reflects register state at the edge where the read is sampled. A write followed by a read on the next cycle sees the write.
- A frame's last bit (the stop bit) is sampled about CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 2 cycles after the falling edge on uart_rx (synchronizer plus FSM). rx_valid rises the cycle after that sample.

## Structure
- Package uart_register_port_pkg holds:
  - register offsets (DATA = 0, STATUS = 1, RX_ACK = 2);
  - STATUS bit positions;
  - the TX and RX state encodings.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) provides push, pop, full, empty and head data.
- Bit timing, the FSMs and register decode stay in the top module.

## Test plan
The bench uses CLKS_PER_BIT = 4 and BASE_INDEX = 12'h010.
- Reset, then read STATUS at 0x011 → 16'h0002 (tx_idle) one cycle later; uart_tx = 1.
- Write 8'hA5 to 0x010 → uart_tx goes low 2 cycles later, then shows bits 1,0,1,0,0,1,0,1 at 4 cycles each, then a stop bit of 1; STATUS returns to 16'h0002 after 40 cycles.
- Write 10 bytes while the first is still transmitting → STATUS bit 0 = 1 once 8 are queued; exactly 9 frames are transmitted in order; the last write is dropped.
- Drive frame 8'h3C on uart_rx → rx_valid = 1 and a read of 0x010 returns 16'h003C. Drive 8'h7E without RX_ACK → STATUS = 16'h000E (overrun set) and DATA = 16'h007E. Write 0x011 and 0x012 → STATUS = 16'h0002.
- Drive a frame with stop bit 0 → frame_err = 1 (STATUS = 16'h0012) and rx_valid stays 0. A 1-cycle low glitch on uart_rx → no flag changes.
- Assert reset in the middle of a TX frame → uart_tx = 1 the next cycle; FIFO empty; STATUS = 16'h0002.

Source files
------------

// File: rtl/uart_register_port_pkg.sv
// Shared definitions for the UART register port.
//   - Register offsets relative to the block's base index.
//   - Bit positions inside the STATUS register.
//   - State encodings for the transmit and receive bit-timing FSMs.
package uart_register_port_pkg;

    localparam logic [11:0] OFF_DATA   = 12'd0;
    localparam logic [11:0] OFF_STATUS = 12'd1;
    localparam logic [11:0] OFF_RX_ACK = 12'd2;

    localparam int STAT_TX_FULL   = 0;
    localparam int STAT_TX_IDLE   = 1;
    localparam int STAT_RX_VALID  = 2;
    localparam int STAT_OVERRUN   = 3;
    localparam int STAT_FRAME_ERR = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_register_port_fifo.sv
// Synchronous FIFO with a combinational view of the head entry.
//   clk, reset        : clock, synchronous active-high reset
//   push, push_data   : enqueue request and data
//   pop               : dequeue request (ignored when empty)
//   head_data         : oldest entry, valid while !empty
//   full, empty       : occupancy flags
// A push while full is accepted only if a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == (AW+1)'(DEPTH));
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign head_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_register_port.sv
// Memory-mapped UART: 8N1 transmitter fed by a FIFO, single-byte receiver.
//   clk, reset             : clock, synchronous active-high reset
//   register_index         : 12-bit register index from the core
//   register_read/_write   : access strobes
//   register_write_value   : write data, bits [7:0] used
//   register_read_value    : registered read data, one cycle after the read
//   uart_tx                : serial output, idle high
//   uart_rx                : asynchronous serial input
// Registers: BASE+0 DATA (W: push TX byte, R: rx byte),
//            BASE+1 STATUS (R: flags, W: clear overrun/frame_err),
//            BASE+2 RX_ACK (W: clear rx_valid).
module uart_register_port
    import uart_register_port_pkg::*;
#(
    parameter logic [11:0] BASE_INDEX   = 12'h010,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          TX_DEPTH     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] register_index,
    input  logic        register_read,
    input  logic        register_write,
    input  logic [15:0] register_write_value,
    output logic [15:0] register_read_value,
    output logic        uart_tx,
    input  logic        uart_rx
);
    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    // ---------------- register decode ----------------
    logic sel_data, sel_status, sel_rx_ack;
    logic data_wr, status_wr, rx_ack_wr;

    assign sel_data   = (register_index == BASE_INDEX + OFF_DATA);
    assign sel_status = (register_index == BASE_INDEX + OFF_STATUS);
    assign sel_rx_ack = (register_index == BASE_INDEX + OFF_RX_ACK);
    assign data_wr    = register_write && sel_data;
    assign status_wr  = register_write && sel_status;
    assign rx_ack_wr  = register_write && sel_rx_ack;

    logic unused_write_bits;
    assign unused_write_bits = ^register_write_value[15:8];

    // ---------------- transmit FIFO ----------------
    logic       fifo_pop, fifo_full, fifo_empty;
    logic [7:0] fifo_head;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (data_wr),
        .push_data (register_write_value[7:0]),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ---------------- TX FSM ----------------
    tx_state_t     tx_state_reg, tx_state_next;
    logic [CW-1:0] tx_cnt_reg, tx_cnt_next;
    logic [2:0]    tx_bit_reg, tx_bit_next;
    logic [7:0]    tx_shift_reg, tx_shift_next;
    logic          tx_line_reg, tx_line_next;

    // The line level is registered, so uart_tx trails the state by one cycle.
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        tx_line_next  = 1'b1;
        fifo_pop      = 1'b0;
        case (tx_state_reg)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    tx_shift_next = fifo_head;
                    tx_cnt_next   = '0;
                    tx_state_next = TX_START;
                end
            end
            TX_START: begin
                tx_line_next = 1'b0;
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_bit_next   = 3'd0;
                    tx_state_next = TX_DATA;
                end else begin
                    tx_cnt_next = tx_cnt_reg + CW'(1);
                end
            end
            TX_DATA: begin
                tx_line_next = tx_shift_reg[0];
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                    tx_bit_next   = tx_bit_reg + 3'd1;
                    if (tx_bit_reg == 3'd7) begin
                        tx_state_next = TX_STOP;
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + CW'(1);
                end
            end
            TX_STOP: begin
                tx_line_next = 1'b1;
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next = '0;
                    // Chain straight into the next queued byte: no idle gap.
                    if (!fifo_empty) begin
                        fifo_pop      = 1'b1;
                        tx_shift_next = fifo_head;
                        tx_state_next = TX_START;
                    end else begin
                        tx_state_next = TX_IDLE;
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + CW'(1);
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            tx_line_reg  <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
            tx_line_reg  <= tx_line_next;
        end
    end

    assign uart_tx = tx_line_reg;

    // ---------------- RX synchronizer + FSM ----------------
    logic          rx_meta_reg, rx_sync_reg;
    rx_state_t     rx_state_reg, rx_state_next;
    logic [CW-1:0] rx_cnt_reg, rx_cnt_next;
    logic [2:0]    rx_bit_reg, rx_bit_next;
    logic [7:0]    rx_shift_reg, rx_shift_next;
    logic          rx_done_ok, rx_done_bad;

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_done_ok    = 1'b0;
        rx_done_bad   = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                if (!rx_sync_reg) begin
                    rx_cnt_next   = '0;
                    rx_state_next = RX_START;
                end
            end
            RX_START: begin
                // Re-check the line at mid start bit to reject short glitches.
                if (rx_cnt_reg == HALF_LAST) begin
                    rx_cnt_next   = '0;
                    rx_bit_next   = 3'd0;
                    rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_next = rx_cnt_reg + CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
                    rx_bit_next   = rx_bit_reg + 3'd1;
                    if (rx_bit_reg == 3'd7) begin
                        rx_state_next = RX_STOP;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg + CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_state_next = RX_IDLE;
                    rx_done_ok    = rx_sync_reg;
                    rx_done_bad   = !rx_sync_reg;
                end else begin
                    rx_cnt_next = rx_cnt_reg + CW'(1);
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
        end else begin
            rx_meta_reg  <= uart_rx;
            rx_sync_reg  <= rx_meta_reg;
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
        end
    end

    // ---------------- receive flags ----------------
    // Set events take priority over a clearing write on the same edge.
    logic [7:0] rx_byte_reg;
    logic       rx_valid_reg, overrun_reg, frame_err_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_byte_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            if (rx_done_ok) begin
                rx_byte_reg  <= rx_shift_reg;
                rx_valid_reg <= 1'b1;
            end else if (rx_ack_wr) begin
                rx_valid_reg <= 1'b0;
            end
            if (rx_done_ok && rx_valid_reg) begin
                overrun_reg <= 1'b1;
            end else if (status_wr) begin
                overrun_reg <= 1'b0;
            end
            if (rx_done_bad) begin
                frame_err_reg <= 1'b1;
            end else if (status_wr) begin
                frame_err_reg <= 1'b0;
            end
        end
    end

    // ---------------- read path ----------------
    logic [4:0]  status_vec;
    logic [15:0] read_mux;

    always_comb begin
        status_vec                 = '0;
        status_vec[STAT_TX_FULL]   = fifo_full;
        status_vec[STAT_TX_IDLE]   = fifo_empty && (tx_state_reg == TX_IDLE);
        status_vec[STAT_RX_VALID]  = rx_valid_reg;
        status_vec[STAT_OVERRUN]   = overrun_reg;
        status_vec[STAT_FRAME_ERR] = frame_err_reg;
    end

    always_comb begin
        read_mux = 16'h0000;
        if (sel_data) begin
            read_mux = {8'h00, rx_byte_reg};
        end else if (sel_status) begin
            read_mux = {11'b0, status_vec};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            register_read_value <= 16'h0000;
        end else if (register_read) begin
            register_read_value <= read_mux;
        end
    end

endmodule

// File: tb/tb_uart_register_port.sv
// Bench for uart_register_port with CLKS_PER_BIT = 4, BASE_INDEX = 12'h010.
// Transmit behaviour is modelled at frame level: each accepted byte gets a
// pop edge P; its frame occupies uart_tx for 40 cycles starting at P+1.
module tb_uart_register_port;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] register_index = 12'h000;
    logic        register_read = 1'b0;
    logic        register_write = 1'b0;
    logic [15:0] register_write_value = 16'h0000;
    logic [15:0] register_read_value;
    logic        uart_tx;
    logic        uart_rx = 1'b1;

    uart_register_port #(
        .BASE_INDEX   (12'h010),
        .CLKS_PER_BIT (CPB),
        .TX_DEPTH     (8)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .register_index       (register_index),
        .register_read        (register_read),
        .register_write       (register_write),
        .register_write_value (register_write_value),
        .register_read_value  (register_read_value),
        .uart_tx              (uart_tx),
        .uart_rx              (uart_rx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        int         n;   // edge of the accepting write
        int         p;   // edge at which the byte leaves the FIFO
        logic [7:0] b;
    } frame_t;

    frame_t     fq[$];
    int         rst_edge = 0;
    logic       m_rx_valid = 1'b0, m_overrun = 1'b0, m_fe = 1'b0;
    logic [7:0] m_rx_byte = 8'h00;
    logic [15:0] last_rd = 16'h0000;

    function automatic bit live(frame_t f, int e);
        return !(f.n < rst_edge && e >= rst_edge);
    endfunction

    function automatic int fifo_cnt(int e);
        int c = 0;
        foreach (fq[i]) if (live(fq[i], e) && fq[i].n <= e && fq[i].p > e) c++;
        return c;
    endfunction

    function automatic bit fsm_busy(int e);
        foreach (fq[i]) if (live(fq[i], e) && fq[i].p <= e && e < fq[i].p + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_tx(int e);
        int s, k;
        foreach (fq[i]) begin
            s = fq[i].p + 1;
            if (live(fq[i], e) && e >= s && e < s + FRAME) begin
                k = (e - s) / CPB;
                if (k == 0) return 1'b0;
                if (k == 9) return 1'b1;
                return fq[i].b[k-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic [15:0] exp_status(int e);
        int c = fifo_cnt(e);
        return {11'b0, m_fe, m_overrun, m_rx_valid, (c == 0) && !fsm_busy(e), c == 8};
    endfunction

    task automatic model_push(int n, logic [7:0] b);
        frame_t f;
        int     pop_edge;
        if (fifo_cnt(n - 1) - ((fifo_cnt(n - 1) > 0 && !fsm_busy(n - 1)) ? 0 : 0) >= 0) begin
        end
        // Occupancy just before edge n, minus an entry popped on edge n.
        pop_edge = 0;
        foreach (fq[i]) if (live(fq[i], n) && fq[i].p > n) pop_edge++;
        if (pop_edge < 8) begin
            f.n = n;
            f.p = n + 1;
            f.b = b;
            if (fq.size() > 0 && live(fq[$], n) && fq[$].p + FRAME > f.p) f.p = fq[$].p + FRAME;
            fq.push_back(f);
        end
    endtask

    // ---------------- drivers (start and end on a falling edge) ----------------
    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [11:0] idx, input logic [15:0] v);
        register_index = idx;
        register_write_value = v;
        register_write = 1'b1;
        if (idx == 12'h010) model_push(cyc + 1, v[7:0]);
        else if (idx == 12'h011) begin m_overrun = 1'b0; m_fe = 1'b0; end
        else if (idx == 12'h012) m_rx_valid = 1'b0;
        @(negedge clk);
        register_write = 1'b0;
        $display("write idx=%h data=%h edge=%0d", idx, v, cyc);
    endtask

    task automatic rd(input string name, input logic [11:0] idx, output logic [15:0] v);
        logic [15:0] exp;
        exp = (idx == 12'h010) ? {8'h00, m_rx_byte} :
              (idx == 12'h011) ? exp_status(cyc) : 16'h0000;
        register_index = idx;
        register_read = 1'b1;
        @(negedge clk);
        register_read = 1'b0;
        check16(name, register_read_value, exp);
        v = register_read_value;
        last_rd = exp;
        $display("read  idx=%h data=%h expected=%h", idx, v, exp);
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            idle(CPB);
        end
        uart_rx = stop_bit;
        idle(CPB);
        uart_rx = 1'b1;
        idle(12);
        if (stop_bit) begin
            if (m_rx_valid) m_overrun = 1'b1;
            m_rx_valid = 1'b1;
            m_rx_byte = b;
        end else begin
            m_fe = 1'b1;
        end
        $display("rx frame byte=%h stop=%b", b, stop_bit);
    endtask

    // ---------------- per-cycle uart_tx compare ----------------
    bit cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if (uart_tx !== exp_tx(cyc)) begin
                errors++;
                if (errors < 30)
                    $display("FAIL uart_tx cycle %0d: got %b, expected %b", cyc, uart_tx, exp_tx(cyc));
            end
        end
    end

    // ---------------- serial decoder on uart_tx ----------------
    logic [7:0] mon_q[$];
    bit mon_en = 1'b0;
    initial begin
        logic [7:0] mb;
        logic       stopb;
        forever begin
            @(negedge clk);
            if (mon_en && uart_tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    mb[i] = uart_tx;
                end
                repeat (CPB) @(negedge clk);
                stopb = uart_tx;
                check16("tx_stop_bit", {15'b0, stopb}, 16'h0001);
                mon_q.push_back(mb);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] v;
        int          base_sz;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cmp_en = 1'b1;
        mon_en = 1'b1;
        check16("reset_read_value", register_read_value, 16'h0000);
        check16("reset_uart_tx", {15'b0, uart_tx}, 16'h0001);
        rd("status_reset", 12'h011, v);
        check16("status_reset_lit", v, 16'h0002);

        // Single byte A5: low two cycles after the write edge.
        wr(12'h010, 16'h00A5);
        @(negedge clk);
        check16("a5_tx_n1", {15'b0, uart_tx}, 16'h0001);
        @(negedge clk);
        check16("a5_tx_n2", {15'b0, uart_tx}, 16'h0000);
        rd("status_busy", 12'h011, v);
        check16("status_busy_lit", v, 16'h0000);
        idle(45);
        rd("status_after_a5", 12'h011, v);
        check16("status_after_a5_lit", v, 16'h0002);
        check16("a5_frames", 16'(mon_q.size()), 16'd1);
        if (mon_q.size() > 0) check16("a5_byte", {8'h00, mon_q[0]}, 16'h00A5);
        mon_q.delete();

        // Read data holds between reads; unmapped indexes read zero.
        idle(3);
        check16("read_hold", register_read_value, last_rd);
        rd("other_index", 12'h013, v);
        check16("other_index_lit", v, 16'h0000);
        rd("rx_ack_read", 12'h012, v);

        // Burst of 10: one in flight plus 8 queued, the last is dropped.
        base_sz = fq.size();
        for (int i = 0; i < 10; i++) wr(12'h010, 16'(8'h30 + i));
        check16("burst_accepted", 16'(fq.size() - base_sz), 16'd9);
        rd("status_full", 12'h011, v);
        check16("status_full_lit", v, 16'h0001);
        idle(9 * FRAME + 10);
        rd("status_after_burst", 12'h011, v);
        check16("status_after_burst_lit", v, 16'h0002);
        check16("burst_frames", 16'(mon_q.size()), 16'd9);
        for (int i = 0; i < 9 && i < mon_q.size(); i++)
            check16("burst_byte", {8'h00, mon_q[i]}, 16'(8'h30 + i));
        mon_q.delete();

        // Receive path.
        drive_rx(8'h3C, 1'b1);
        rd("status_rx1", 12'h011, v);
        check16("status_rx1_lit", v, 16'h0006);
        rd("data_rx1", 12'h010, v);
        check16("data_rx1_lit", v, 16'h003C);
        drive_rx(8'h7E, 1'b1);
        rd("status_overrun", 12'h011, v);
        check16("status_overrun_lit", v, 16'h000E);
        rd("data_rx2", 12'h010, v);
        check16("data_rx2_lit", v, 16'h007E);
        wr(12'h011, 16'h0000);
        wr(12'h012, 16'h0000);
        rd("status_cleared", 12'h011, v);
        check16("status_cleared_lit", v, 16'h0002);
        drive_rx(8'h5A, 1'b0);
        rd("status_frame_err", 12'h011, v);
        check16("status_frame_err_lit", v, 16'h0012);
        rd("data_after_fe", 12'h010, v);
        check16("data_after_fe_lit", v, 16'h007E);
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        idle(12);
        rd("status_glitch", 12'h011, v);
        check16("status_glitch_lit", v, 16'h0012);

        // Reset in the middle of a transmit frame.
        mon_en = 1'b0;
        wr(12'h010, 16'h0055);
        idle(15);
        rst_edge = cyc + 1;
        m_rx_valid = 1'b0;
        m_overrun = 1'b0;
        m_fe = 1'b0;
        m_rx_byte = 8'h00;
        reset = 1'b1;
        @(negedge clk);
        check16("tx_after_reset", {15'b0, uart_tx}, 16'h0001);
        reset = 1'b0;
        idle(2);
        rd("status_after_reset", 12'h011, v);
        check16("status_after_reset_lit", v, 16'h0002);
        rd("data_after_reset", 12'h010, v);
        check16("data_after_reset_lit", v, 16'h0000);
        wr(12'h010, 16'h0096);
        idle(50);
        rd("status_final", 12'h011, v);
        check16("status_final_lit", v, 16'h0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
